// File: rtl/spi_rx_8lane_deser.sv
// Receive-side deserializer for the 8-lane SPI link. Resynchronizes SCLK,
// CS_n and the data lanes into clk, captures one lane-byte per SCLK rise
// and publishes each complete 16-byte frame as a 128-bit block.
module spi_rx_8lane_deser #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         spi_sclk,
   input  logic         spi_cs_n,
   input  logic [7:0]   spi_data,
   output logic [127:0] rx_data,
   output logic         rx_valid,
   output logic         rx_busy,
   output logic         frame_err,
   output logic [4:0]   byte_count
);

   localparam int unsigned LANE_W     = 8;
   localparam int unsigned BLOCK_W    = 128;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned IDX_W      = 7;
   localparam int unsigned LAST_SLOT  = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_next;

   logic [SYNC_STAGES-1:0]             sclk_sync;
   logic [SYNC_STAGES-1:0]             cs_sync;
   logic [SYNC_STAGES-1:0][LANE_W-1:0] data_sync;
   logic                               sclk_q;

   logic              sclk_s, cs_s, sclk_rise, cs_active;
   logic [LANE_W-1:0] data_s;

   logic [BLOCK_W-1:0] shift_q;
   logic [BLOCK_W-1:0] assembled_c;
   logic [IDX_W-1:0]   slot_idx;

   logic capture_c, complete_c, abort_c;

   // Equal-depth synchronizers keep lane data aligned with SCLK; sclk_q feeds edge detect
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         data_sync <= '0;
         sclk_q    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
         sclk_q    <= sclk_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign data_s    = data_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign cs_active = ~cs_s;

   // Current shift contents with the incoming byte dropped into its slot
   assign slot_idx = IDX_W'({byte_count[3:0], 3'b000});
   always_comb begin
      assembled_c = shift_q;
      assembled_c[slot_idx +: LANE_W] = data_s;
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_next;
   end

   // Next state and capture decisions; a CS release outranks a same-cycle SCLK rise
   always_comb begin
      state_next = state_q;
      capture_c  = 1'b0;
      complete_c = 1'b0;
      abort_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_active) state_next = RECV;
         end
         RECV: begin
            if (!cs_active) begin
               state_next = IDLE;
               abort_c    = (byte_count != CNT_W'(0));
            end else if (sclk_rise) begin
               capture_c = 1'b1;
               if (byte_count == CNT_W'(LAST_SLOT)) begin
                  complete_c = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (!cs_active) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Byte assembly, block publish and status outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift_q    <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
         byte_count <= '0;
      end else begin
         rx_valid  <= complete_c;
         frame_err <= abort_c;
         rx_busy   <= (state_next == RECV);
         if (capture_c)  shift_q <= assembled_c;
         if (complete_c) rx_data <= assembled_c;
         if (state_next == IDLE)  byte_count <= '0;
         else if (capture_c)      byte_count <= byte_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_spi_rx_8lane_deser.sv
// Scoreboard bench for spi_rx_8lane_deser: directed test-plan frames plus
// random frames; expected blocks/errors are queued by the stimulus and
// matched against rx_valid / frame_err pulses by an independent monitor.
module tb_spi_rx_8lane_deser;

   typedef struct {
      bit           err;
      logic [127:0] data;
   } exp_t;

   logic         clk, resetn, spi_sclk, spi_cs_n;
   logic [7:0]   spi_data;
   logic [127:0] rx_data;
   logic         rx_valid, rx_busy, frame_err;
   logic [4:0]   byte_count;

   exp_t         sbq[$];
   logic [7:0]   fb [0:31];
   logic [127:0] model_last;
   int           vectors, miscompares;

   spi_rx_8lane_deser #(.SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_data(spi_data), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_busy(rx_busy), .frame_err(frame_err), .byte_count(byte_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every output event must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (resetn && (rx_valid || frame_err)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_event", 128'({rx_valid, frame_err}), 128'(0));
         end else begin
            e = sbq.pop_front();
            chk(e.err ? "err_kind" : "valid_kind", 128'({rx_valid, frame_err}),
                e.err ? 128'(2'b01) : 128'(2'b10));
            chk(e.err ? "err_rx_data_held" : "block_data", rx_data, e.data);
         end
      end
   end

   // Sends n bytes from fb with SCLK half period hp; race releases CS on the 16th rise
   task automatic send_frame(input int n, input int hp, input bit race, input bit keep_cs);
      exp_t e;
      logic [127:0] blk;
      blk = '0;
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = fb[k];
      if (race) begin
         e.err = 1'b1; e.data = model_last; sbq.push_back(e);
      end else if (n >= 16) begin
         e.err = 1'b0; e.data = blk; sbq.push_back(e);
         model_last = blk;
      end else if (n >= 1 && !keep_cs) begin
         e.err = 1'b1; e.data = model_last; sbq.push_back(e);
      end
      spi_cs_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         spi_data = fb[i];
         #hp;
         if (i >= 1) chk("byte_count_mid", 128'(byte_count), 128'((i < 16) ? i : 16));
         spi_sclk = 1'b1;
         if (race && i == n - 1) spi_cs_n = 1'b1;
         #hp;
         spi_sclk = 1'b0;
      end
      if (race) return;
      #hp;
      chk("byte_count_end", 128'(byte_count), 128'((n < 16) ? n : 16));
      chk("busy_end", 128'(rx_busy), 128'(n < 16));
      if (!keep_cs) begin
         spi_cs_n = 1'b1;
         #hp;
      end
   endtask

   // Quiet period between frames: block idle, rx_data holding the last good block
   task automatic idle_check();
      #100;
      chk("idle_byte_count", 128'(byte_count), 128'(0));
      chk("idle_busy", 128'(rx_busy), 128'(0));
      chk("idle_rx_data", rx_data, model_last);
   endtask

   initial begin
      int n, hp;
      bit race;
      vectors = 0; miscompares = 0; model_last = '0;
      resetn = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_data = 8'h00;
      #32;
      chk("rst_rx_data", rx_data, 128'(0));
      chk("rst_flags", 128'({rx_valid, rx_busy, frame_err}), 128'(0));
      chk("rst_byte_count", 128'(byte_count), 128'(0));
      resetn = 1'b1;
      #20;

      // Single frame 0x00..0x0F
      for (int i = 0; i < 16; i++) fb[i] = 8'(i);
      send_frame(16, 30, 1'b0, 1'b0);
      idle_check();
      chk("single_frame_block", model_last, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

      // Short frame of five 0xAA
      for (int i = 0; i < 16; i++) fb[i] = 8'hAA;
      send_frame(5, 30, 1'b0, 1'b0);
      idle_check();

      // Overlong frame 0x10..0x21
      for (int i = 0; i < 18; i++) fb[i] = 8'(8'h10 + i);
      send_frame(18, 30, 1'b0, 1'b0);
      idle_check();

      // Back-to-back at f_clk = 4 x f_sclk with minimum CS gap
      for (int i = 0; i < 16; i++) fb[i] = 8'h5A;
      send_frame(16, 20, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) fb[i] = 8'hC3;
      send_frame(16, 20, 1'b0, 1'b0);
      idle_check();

      // Reset after byte 7 with CS still low, then a full 0xFF frame
      for (int i = 0; i < 16; i++) fb[i] = 8'(i + 1);
      send_frame(7, 30, 1'b0, 1'b1);
      resetn = 1'b0;
      model_last = '0;
      #20;
      chk("midrst_rx_data", rx_data, 128'(0));
      chk("midrst_flags", 128'({rx_valid, rx_busy, frame_err}), 128'(0));
      chk("midrst_byte_count", 128'(byte_count), 128'(0));
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) fb[i] = 8'hFF;
      send_frame(16, 30, 1'b0, 1'b0);
      idle_check();

      // CS release coincident with the 16th SCLK rise
      for (int i = 0; i < 16; i++) fb[i] = 8'h77;
      send_frame(16, 30, 1'b1, 1'b0);
      idle_check();

      // Silent empty frame
      send_frame(0, 30, 1'b0, 1'b0);
      idle_check();

      // Random frames
      for (int f = 0; f < 40; f++) begin
         n    = int'($urandom_range(0, 20));
         hp   = 10 * int'($urandom_range(2, 4));
         race = (n == 16) && ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
         send_frame(n, hp, race, 1'b0);
         if ($urandom_range(0, 2) != 0) idle_check();
      end
      idle_check();

      for (int c = 0; c < 100 && sbq.size() != 0; c++) @(posedge clk);
      chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
